fault_fsm: RTL and testbench

//   Downstream of the ADC threshold comparator. Consumes its ov_flag/uv_flag and qualifies faults by persistence.

---
 rtl/fault_fsm_pkg.sv | 21 ++
 rtl/fault_persist_cnt.sv | 31 +++
 rtl/fault_fsm.sv | 180 ++++++++++++++++++
 tb/tb_fault_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fault_fsm_pkg.sv
// Shared definitions for the fault qualification FSM.
//   fsm_state_t : state encodings as seen on the 'state' output
//   FC_OV/FC_UV : bit positions inside fault_code
//   sat_inc8    : saturating increment for the 8-bit lifetime fault counter
package fault_fsm_pkg;

  typedef enum logic [2:0] {
    FS_NORMAL  = 3'd0,
    FS_QUALIFY = 3'd1,
    FS_FAULT   = 3'd2,
    FS_LOCKOUT = 3'd3
  } fsm_state_t;

  localparam int FC_OV = 0;
  localparam int FC_UV = 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fault_persist_cnt.sv
// Persistence counter: clear / increment / terminal-count.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the count (has priority over inc)
//   inc      : advance the count; holds at TERM-1 so it never wraps
//   tc       : 1 while the count equals TERM-1
module fault_persist_cnt #(
  parameter int unsigned TERM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int unsigned W = $clog2(TERM + 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(TERM - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fault_fsm.sv
// Fault qualification and auto-retry controller.
// Sits behind the ADC threshold comparator: a fault is qualified once the
// combined OV/UV flag has been present for DEB_CYCLES consecutive samples.
// Each qualified fault drops power; after RECOV_CYCLES clean samples power
// is retried. MAX_RETRY faults without an intervening stable period
// (STABLE_CYCLES clean cycles in NORMAL) latch LOCKOUT, released only by
// clear_req while the flags are clean. All outputs are registered.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   ov_flag       : over-voltage flag (hysteresis-filtered)
//   uv_flag       : under-voltage flag (hysteresis-filtered)
//   clear_req     : operator clear, honoured only in LOCKOUT
//   pwr_enable    : power stage may run
//   fault_active  : FAULT or LOCKOUT
//   lockout       : LOCKOUT
//   fault_code    : {uv,ov} seen during the last qualification (sticky)
//   retry_cnt     : qualified faults since last stable period / clear
//   fault_count   : lifetime qualified faults, saturating at 255
//   state         : NORMAL=0, QUALIFY=1, FAULT=2, LOCKOUT=3
module fault_fsm
  import fault_fsm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 8,
  parameter int unsigned RECOV_CYCLES  = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned STABLE_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ov_flag,
  input  logic       uv_flag,
  input  logic       clear_req,
  output logic       pwr_enable,
  output logic       fault_active,
  output logic       lockout,
  output logic [1:0] fault_code,
  output logic [3:0] retry_cnt,
  output logic [7:0] fault_count,
  output logic [2:0] state
);

  fsm_state_t state_q, state_d;
  logic [1:0] flags;
  logic       flag;
  logic [1:0] seen_q, seen_d;
  logic       pwr_d, fa_d, lock_d;
  logic [1:0] code_d;
  logic [3:0] retry_d;
  logic [7:0] count_d;
  logic       qualify, illegal;
  logic       deb_clr, deb_inc, deb_tc;
  logic       rec_clr, rec_inc, rec_tc;
  logic       stab_clr, stab_inc, stab_tc;

  always_comb begin
    flags        = '0;
    flags[FC_OV] = ov_flag;
    flags[FC_UV] = uv_flag;
  end

  assign flag  = ov_flag | uv_flag;
  assign state = state_q;

  fault_persist_cnt #(.TERM(DEB_CYCLES)) u_deb (
    .clk(clk), .rst(rst), .clr(deb_clr), .inc(deb_inc), .tc(deb_tc)
  );

  fault_persist_cnt #(.TERM(RECOV_CYCLES)) u_rec (
    .clk(clk), .rst(rst), .clr(rec_clr), .inc(rec_inc), .tc(rec_tc)
  );

  fault_persist_cnt #(.TERM(STABLE_CYCLES)) u_stab (
    .clk(clk), .rst(rst), .clr(stab_clr), .inc(stab_inc), .tc(stab_tc)
  );

  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    code_d   = fault_code;
    retry_d  = retry_cnt;
    count_d  = fault_count;
    qualify  = 1'b0;
    illegal  = 1'b0;
    // Counters idle at zero unless the current state is actively using them.
    deb_clr  = 1'b1;
    deb_inc  = 1'b0;
    rec_clr  = 1'b1;
    rec_inc  = 1'b0;
    stab_clr = 1'b1;
    stab_inc = 1'b0;

    case (state_q)
      FS_NORMAL: begin
        if (flag) begin
          // First flagged sample counts as sample 1 of the debounce run.
          state_d = FS_QUALIFY;
          seen_d  = flags;
          deb_clr = 1'b0;
          deb_inc = 1'b1;
        end else if (stab_tc) begin
          retry_d = '0;
        end else begin
          stab_clr = 1'b0;
          stab_inc = 1'b1;
        end
      end
      FS_QUALIFY: begin
        if (!flag) begin
          state_d = FS_NORMAL;
          seen_d  = '0;
        end else if (deb_tc) begin
          qualify = 1'b1;
        end else begin
          seen_d  = seen_q | flags;
          deb_clr = 1'b0;
          deb_inc = 1'b1;
        end
      end
      FS_FAULT: begin
        // Any flagged sample restarts the recovery run.
        if (!flag) begin
          if (rec_tc) begin
            state_d = FS_NORMAL;
          end else begin
            rec_clr = 1'b0;
            rec_inc = 1'b1;
          end
        end
      end
      FS_LOCKOUT: begin
        if (clear_req && !flag) begin
          state_d = FS_NORMAL;
          retry_d = '0;
        end
      end
      default: begin
        state_d = FS_NORMAL;
        illegal = 1'b1;
      end
    endcase

    if (qualify) begin
      // The qualifying sample itself contributes to the fault code.
      code_d  = seen_q | flags;
      seen_d  = '0;
      count_d = sat_inc8(fault_count);
      retry_d = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
      state_d = (retry_d == 4'(MAX_RETRY)) ? FS_LOCKOUT : FS_FAULT;
    end

    // Outputs follow the next state so they are valid on the transition edge;
    // an illegal encoding holds power off for the one recovery cycle.
    pwr_d  = !illegal && ((state_d == FS_NORMAL) || (state_d == FS_QUALIFY));
    fa_d   = (state_d == FS_FAULT) || (state_d == FS_LOCKOUT);
    lock_d = (state_d == FS_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FS_NORMAL;
      seen_q       <= '0;
      pwr_enable   <= 1'b1;
      fault_active <= 1'b0;
      lockout      <= 1'b0;
      fault_code   <= '0;
      retry_cnt    <= '0;
      fault_count  <= '0;
    end else begin
      state_q      <= state_d;
      seen_q       <= seen_d;
      pwr_enable   <= pwr_d;
      fault_active <= fa_d;
      lockout      <= lock_d;
      fault_code   <= code_d;
      retry_cnt    <= retry_d;
      fault_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_fault_fsm.sv
// Bench for fault_fsm: behavioural reference model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_fault_fsm;

  localparam int DEB  = 4;
  localparam int REC  = 8;
  localparam int MAXR = 2;
  localparam int STAB = 16;

  logic       clk = 1'b0;
  logic       rst, ov_flag, uv_flag, clear_req;
  logic       pwr_enable, fault_active, lockout;
  logic [1:0] fault_code;
  logic [3:0] retry_cnt;
  logic [7:0] fault_count;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Reference model: phases described as run lengths of samples.
  int m_state, m_code, m_retry, m_count, m_seen;
  int m_run, m_clean, m_stable;

  fault_fsm #(
    .DEB_CYCLES(DEB), .RECOV_CYCLES(REC), .MAX_RETRY(MAXR), .STABLE_CYCLES(STAB)
  ) dut (
    .clk(clk), .rst(rst), .ov_flag(ov_flag), .uv_flag(uv_flag),
    .clear_req(clear_req), .pwr_enable(pwr_enable), .fault_active(fault_active),
    .lockout(lockout), .fault_code(fault_code), .retry_cnt(retry_cnt),
    .fault_count(fault_count), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit o, input bit u, input bit c);
    bit f;
    f = o | u;
    if (r) begin
      m_state = 0; m_code = 0; m_retry = 0; m_count = 0; m_seen = 0;
      m_run = 0; m_clean = 0; m_stable = 0;
      return;
    end
    case (m_state)
      0: begin
        if (f) begin
          m_state = 1; m_run = 1; m_seen = (u ? 2 : 0) + (o ? 1 : 0);
        end else begin
          m_stable++;
          if (m_stable == STAB) begin m_retry = 0; m_stable = 0; end
        end
      end
      1: begin
        if (!f) begin
          m_state = 0; m_run = 0; m_seen = 0; m_stable = 0;
        end else begin
          m_run++;
          m_seen = m_seen | (u ? 2 : 0) | (o ? 1 : 0);
          if (m_run == DEB) begin
            m_code  = m_seen;
            m_count = (m_count < 255) ? m_count + 1 : 255;
            m_retry++;
            m_clean = 0;
            m_state = (m_retry == MAXR) ? 3 : 2;
          end
        end
      end
      2: begin
        if (f) m_clean = 0;
        else begin
          m_clean++;
          if (m_clean == REC) begin m_state = 0; m_stable = 0; end
        end
      end
      default: begin
        if (c && !f) begin m_state = 0; m_retry = 0; m_stable = 0; end
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("state",        state,        m_state);
      chk("pwr_enable",   pwr_enable,   (m_state < 2) ? 1 : 0);
      chk("fault_active", fault_active, (m_state >= 2) ? 1 : 0);
      chk("lockout",      lockout,      (m_state == 3) ? 1 : 0);
      chk("fault_code",   fault_code,   m_code);
      chk("retry_cnt",    retry_cnt,    m_retry);
      chk("fault_count",  fault_count,  m_count);
    end
  end

  task automatic step(input bit r, input bit o, input bit u, input bit c);
    rst = r; ov_flag = o; uv_flag = u; clear_req = c;
    @(posedge clk);
    model_step(r, o, u, c);
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n, input bit o, input bit u, input bit c);
    for (int i = 0; i < n; i++) step(1'b0, o, u, c);
  endtask

  initial begin
    rst = 1'b1; ov_flag = 1'b0; uv_flag = 1'b0; clear_req = 1'b0;

    // 1. Reset
    step(1, 0, 0, 0);
    checking = 1;
    step(1, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_pwr", pwr_enable, 1);
    chk("rst_fa", fault_active, 0);
    chk("rst_count", fault_count, 0);

    // 2. Glitch shorter than debounce
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("glitch_qualify", state, 1);
    end
    step(0, 0, 0, 0);
    chk("glitch_back", state, 0);
    chk("glitch_count", fault_count, 0);

    // 3. Qualify and recover
    steps(4, 1, 0, 0);
    chk("q_state", state, 2);
    chk("q_pwr", pwr_enable, 0);
    chk("q_code", fault_code, 1);
    chk("q_retry", retry_cnt, 1);
    chk("q_count", fault_count, 1);
    steps(5, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("rec_restart", state, 2);
    steps(7, 0, 0, 0);
    chk("rec_7", state, 2);
    step(0, 0, 0, 0);
    chk("rec_8_state", state, 0);
    chk("rec_8_pwr", pwr_enable, 1);

    // 6a. Stable period clears retry_cnt
    steps(15, 0, 0, 0);
    chk("stab_15", retry_cnt, 1);
    step(0, 0, 0, 0);
    chk("stab_16", retry_cnt, 0);

    // 4. Mixed UV then OV
    steps(2, 0, 1, 0);
    steps(2, 1, 0, 0);
    chk("mix_state", state, 2);
    chk("mix_code", fault_code, 3);
    chk("mix_retry", retry_cnt, 1);

    // 5. Lockout on second fault without a stable period
    steps(8, 0, 0, 0);
    steps(4, 1, 0, 0);
    chk("lo_state", state, 3);
    chk("lo_lock", lockout, 1);
    chk("lo_retry", retry_cnt, 2);
    chk("lo_count", fault_count, 3);
    step(0, 0, 1, 1);
    chk("lo_clear_flagged", state, 3);
    steps(20, 0, 0, 0);
    chk("lo_held", state, 3);
    step(0, 0, 0, 1);
    chk("clr_state", state, 0);
    chk("clr_retry", retry_cnt, 0);
    chk("clr_code_kept", fault_code, 1);
    chk("clr_pwr", pwr_enable, 1);

    // 6b. Reset while in FAULT
    steps(4, 1, 0, 0);
    chk("f_state", state, 2);
    step(1, 1, 0, 0);
    chk("rstf_state", state, 0);
    chk("rstf_pwr", pwr_enable, 1);
    chk("rstf_code", fault_code, 0);
    chk("rstf_count", fault_count, 0);

    // fault_count saturation
    for (int k = 0; k < 130; k++) begin
      steps(4, 1, 0, 0);
      steps(8, 0, 0, 0);
      steps(4, 0, 1, 0);
      step(0, 0, 0, 1);
    end
    chk("sat_count", fault_count, 255);
    chk("sat_state", state, 0);

    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
